noc_switch_allocator: RTL



---
 rtl/noc_switch_allocator_pkg.sv | 22 ++
 rtl/noc_switch_allocator_rr_arbiter.sv | 28 ++
 rtl/noc_switch_allocator.sv | 138 +++++++++++++
 3 files changed

// File: rtl/noc_switch_allocator_pkg.sv
// Shared types and constants for the NoC router switch allocator.
// Port/direction encoding is fixed: N=0 S=1 W=2 E=3 L=4.
package noc_pkg;

  localparam int unsigned NUM_PORTS = 5;
  localparam int unsigned SEL_W     = 3;
  localparam logic [SEL_W-1:0] SEL_NONE = 3'b111;

  typedef enum logic [SEL_W-1:0] {
    DIR_N = 3'd0,
    DIR_S = 3'd1,
    DIR_W = 3'd2,
    DIR_E = 3'd3,
    DIR_L = 3'd4
  } dir_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_e;

endpackage

// File: rtl/noc_switch_allocator_rr_arbiter.sv
// Combinational round-robin arbiter for one output: picks the first candidate
// after rr_ptr (mod NUM_PORTS), never the output's own index.
module rr_arbiter_4of5
  import noc_pkg::*;
(
  input  logic [NUM_PORTS-1:0] cand,
  input  logic [SEL_W-1:0]     excl,
  input  logic [SEL_W-1:0]     rr_ptr,
  output logic                 grant_valid,
  output logic [SEL_W-1:0]     grant_idx
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      idx = SEL_W'((32'(rr_ptr) + k) % NUM_PORTS);
      if (!grant_valid && (idx != excl) && cand[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/noc_switch_allocator.sv
// 5-port router switch allocator: per-output round-robin arbitration with
// wormhole locking, driving crossbar selects, buffer pops and output valids.
module noc_switch_allocator
  import noc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  req_valid_i,
  input  logic [14:0] req_dir_i,
  input  logic [4:0]  req_tail_i,
  input  logic [4:0]  out_ready_i,
  output logic [14:0] cs_sel_demux_o,
  output logic [14:0] cs_sel_mux_o,
  output logic [4:0]  pop_o,
  output logic [4:0]  out_valid_o,
  output logic [4:0]  route_err_o
);

  logic [SEL_W-1:0]     dir       [NUM_PORTS];
  alloc_state_e         state_q   [NUM_PORTS];
  alloc_state_e         state_d   [NUM_PORTS];
  logic [SEL_W-1:0]     owner_q   [NUM_PORTS];
  logic [SEL_W-1:0]     owner_d   [NUM_PORTS];
  logic [SEL_W-1:0]     rr_q      [NUM_PORTS];
  logic [SEL_W-1:0]     rr_d      [NUM_PORTS];
  logic [NUM_PORTS-1:0] cand      [NUM_PORTS];
  logic [SEL_W-1:0]     gnt_idx   [NUM_PORTS];
  logic [SEL_W-1:0]     mux_sel   [NUM_PORTS];
  logic [SEL_W-1:0]     demux_sel [NUM_PORTS];
  logic [NUM_PORTS-1:0] gnt_valid;
  logic [NUM_PORTS-1:0] xfer;
  logic [NUM_PORTS-1:0] last;
  logic [NUM_PORTS-1:0] locked_q;
  logic [NUM_PORTS-1:0] locked_d;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign dir[g] = req_dir_i[SEL_W*g +: SEL_W];

    // Error flag is held low during reset so every output is quiet then.
    assign route_err_o[g] = rst_n && req_valid_i[g] &&
                            ((dir[g] > DIR_L) || (dir[g] == SEL_W'(g)));

    assign cs_sel_demux_o[SEL_W*g +: SEL_W] = demux_sel[g];
    assign cs_sel_mux_o[SEL_W*g +: SEL_W]   = mux_sel[g];

    // Matching dir==g with g<5 and h!=g already excludes illegal requests.
    for (genvar h = 0; h < NUM_PORTS; h++) begin : g_cand
      assign cand[g][h] = (g != h) && req_valid_i[h] && !locked_q[h] &&
                          (dir[h] == SEL_W'(g));
    end

    rr_arbiter_4of5 u_arb (
      .cand        (cand[g]),
      .excl        (SEL_W'(g)),
      .rr_ptr      (rr_q[g]),
      .grant_valid (gnt_valid[g]),
      .grant_idx   (gnt_idx[g])
    );

    assign xfer[g] = (state_q[g] == LOCKED) && req_valid_i[owner_q[g]] &&
                     out_ready_i[g];
    assign last[g] = xfer[g] && req_tail_i[owner_q[g]];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q[g] <= IDLE;
        owner_q[g] <= '0;
        rr_q[g]    <= SEL_W'(NUM_PORTS - 1);
      end else begin
        state_q[g] <= state_d[g];
        owner_q[g] <= owner_d[g];
        rr_q[g]    <= rr_d[g];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q <= '0;
    end else begin
      locked_q <= locked_d;
    end
  end

  // Next state: an input is never a candidate while locked, so a released
  // input cannot be re-granted in the same cycle it sends its tail.
  always_comb begin
    logic [SEL_W-1:0] pn;
    pn       = '0;
    locked_d = locked_q;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      pn          = SEL_W'(o);
      state_d[pn] = state_q[pn];
      owner_d[pn] = owner_q[pn];
      rr_d[pn]    = rr_q[pn];
      unique case (state_q[pn])
        IDLE: begin
          if (gnt_valid[pn]) begin
            state_d[pn]                = LOCKED;
            owner_d[pn]                = gnt_idx[pn];
            locked_d[gnt_idx[pn]]      = 1'b1;
          end
        end
        LOCKED: begin
          if (last[pn]) begin
            state_d[pn]                = IDLE;
            rr_d[pn]                   = owner_q[pn];
            locked_d[owner_q[pn]]      = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    logic [SEL_W-1:0] po;
    po          = '0;
    pop_o       = '0;
    out_valid_o = '0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      mux_sel[o]   = SEL_NONE;
      demux_sel[o] = SEL_NONE;
    end
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      po = SEL_W'(o);
      if (state_q[po] == LOCKED) begin
        mux_sel[po]            = owner_q[po];
        demux_sel[owner_q[po]] = po;
        if (xfer[po]) begin
          pop_o[owner_q[po]] = 1'b1;
          out_valid_o[po]    = 1'b1;
        end
      end
    end
  end

endmodule
